// File: rtl/mul_shift_add_32_bit.sv
// Multi-cycle unsigned 32x32->64 shift-add multiplier wrapped around an external ripple-carry adder.
// Optional signed mode (magnitude load plus a final NEG step) is enabled with MUL_SIGNED_EN.
module mul_shift_add_32_bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MUL_SIGNED_EN
    input  logic               is_signed,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_x,
    output logic [WIDTH-1:0]   add_y,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_co
);

    typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   a_ld, b_ld;
    logic [2*WIDTH-1:0] shift;

`ifdef MUL_SIGNED_EN
    logic neg_q, neg_d;
    // Negation of 32'h80000000 wraps to itself, which reads correctly as magnitude 2^31.
    assign a_ld = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_ld = (is_signed && b[WIDTH-1]) ? -b : b;
`else
    assign a_ld = a;
    assign b_ld = b;
`endif

    assign add_x = hi_q;
    assign add_y = lo_q[0] ? mcand_q : '0;
    // Carry-out becomes the new top bit, so nothing is lost on the right shift.
    assign shift = {add_co, add_sum, lo_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef MUL_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a_ld;
                    lo_d    = b_ld;
                    hi_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef MUL_SIGNED_EN
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                end
            end
            RUN: begin
                {hi_d, lo_d} = shift;
                cnt_d        = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
`ifdef MUL_SIGNED_EN
                    state_d = NEG;
`else
                    product_d = shift;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
`endif
                end
            end
`ifdef MUL_SIGNED_EN
            NEG: begin
                product_d = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = DONE;
            end
`endif
            DONE: state_d = IDLE;
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MUL_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mul_shift_add_32_bit.sv
// Directed bench for mul_shift_add_32_bit; the bench supplies the 32-bit adder itself.
module tb_mul_shift_add_32_bit;

`ifdef MUL_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [63:0] product;
    logic [31:0] add_x, add_y, add_sum;
    logic        add_co;
`ifdef MUL_SIGNED_EN
    logic        is_signed = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    assign {add_co, add_sum} = {1'b0, add_x} + {1'b0, add_y};

    mul_shift_add_32_bit dut (
        .clk(clk), .rstb(rstb), .start(start), .a(a), .b(b),
`ifdef MUL_SIGNED_EN
        .is_signed(is_signed),
`endif
        .busy(busy), .done(done), .product(product),
        .add_x(add_x), .add_y(add_y), .add_sum(add_sum), .add_co(add_co)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start one multiply; optionally pulse start again at RUN cycles 5 and 20 with other operands.
    task automatic do_mul(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sgn, input logic [63:0] exp, input logic inject);
        int n;
        int d0;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
`ifdef MUL_SIGNED_EN
        is_signed = sgn;
`endif
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D;
        check64({tag, ".busy_run"}, 64'(busy), 64'd1);
        check64({tag, ".add_x0"}, 64'(add_x), 64'd0);
        n = 0;
        while (n < 100) begin
            @(posedge clk); n++; #1;
            if (done === 1'b1) break;
            start = inject && (n == 5 || n == 20);
            if (start) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        end
        start = 1'b0;
        check64({tag, ".latency"}, 64'(n), 64'(LAT));
        check64({tag, ".product"}, product, exp);
        check64({tag, ".busy_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check64({tag, ".done_pulse"}, 64'(done), 64'd0);
        check64({tag, ".held"}, product, exp);
        if (inject) begin
            repeat (40) @(posedge clk);
            #1;
            check64({tag, ".one_done"}, 64'(done_cnt - d0), 64'd1);
            check64({tag, ".idle_after"}, 64'(busy), 64'd0);
        end
        if (sgn) n = 0;
    endtask

    initial begin
        // Reset state
        #12;
        check64("rst.busy", 64'(busy), 64'd0);
        check64("rst.done", 64'(done), 64'd0);
        check64("rst.product", product, 64'd0);
        check64("rst.add_x", 64'(add_x), 64'd0);
        check64("rst.add_y", 64'(add_y), 64'd0);
        @(negedge clk); rstb = 1'b1;
        repeat (2) @(posedge clk);

        do_mul("t1", 32'd3, 32'd5, 1'b0, 64'd15, 1'b0);
        do_mul("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
        do_mul("t3a", 32'd0, 32'h1234_5678, 1'b0, 64'd0, 1'b0);
        do_mul("t3b", 32'h1234_5678, 32'd0, 1'b0, 64'd0, 1'b0);
        do_mul("t4", 32'h0000_1234, 32'h0000_0100, 1'b0, 64'h0000_0000_0012_3400, 1'b1);
        do_mul("t_top", 32'h8000_0000, 32'd4, 1'b0, 64'h0000_0002_0000_0000, 1'b0);

        // Reset abort at iteration 10
        begin
            int d0;
            @(negedge clk);
            a = 32'd7; b = 32'd9; start = 1'b1;
            d0 = done_cnt;
            @(posedge clk); #1; start = 1'b0;
            repeat (10) @(posedge clk);
            #2 rstb = 1'b0;
            #1;
            check64("t5.busy", 64'(busy), 64'd0);
            check64("t5.product", product, 64'd0);
            check64("t5.done", 64'(done), 64'd0);
            @(negedge clk); rstb = 1'b1;
            repeat (40) @(posedge clk);
            #1;
            check64("t5.no_done", 64'(done_cnt - d0), 64'd0);
        end
        do_mul("t5.after", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b0);

`ifdef MUL_SIGNED_EN
        do_mul("t6a", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        do_mul("t6b", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
